// File: rtl/bsg_clk_gen_pearl_tag_serializer.sv
// Serializes bsg_tag packets and master-reset preambles onto the pearl's tag port.
// The outputs come from registers loaded with next-state values, so a new bit shows up right after the edge that produces it.
module bsg_clk_gen_pearl_tag_serializer #(
    parameter int tag_els_p               = 16,
    parameter int tag_max_payload_width_p = 16,
    parameter int reset_len_p             = 64,
    localparam int lg_els_lp   = (tag_els_p > 1) ? $clog2(tag_els_p) : 1,
    localparam int lg_width_lp = $clog2(tag_max_payload_width_p + 1)
) (
    input  logic                               clk_i,
    input  logic                               async_reset_n_i,
    input  logic                               v_i,
    output logic                               ready_and_o,
    input  logic                               master_reset_i,
    input  logic [lg_els_lp-1:0]               node_id_i,
    input  logic                               data_not_reset_i,
    input  logic [lg_width_lp-1:0]             len_i,
    input  logic [tag_max_payload_width_p-1:0] payload_i,
    output logic                               tag_data_o,
    output logic                               tag_en_o,
    output logic                               idle_o
);

    localparam int shift_w_lp = lg_els_lp + 1 + lg_width_lp + tag_max_payload_width_p;
    localparam int cnt_max_a_lp = (reset_len_p > tag_max_payload_width_p) ? reset_len_p : tag_max_payload_width_p;
    localparam int cnt_max_b_lp = (lg_els_lp > lg_width_lp) ? lg_els_lp : lg_width_lp;
    localparam int cnt_max_lp = (cnt_max_a_lp > cnt_max_b_lp) ? cnt_max_a_lp : cnt_max_b_lp;
    localparam int cnt_w_lp = $clog2(cnt_max_lp + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_START, S_NODE, S_DNR, S_LEN, S_PAY, S_GAP
    } state_e;

    state_e                   state_reg, state_next;
    logic [cnt_w_lp-1:0]      cnt_reg, cnt_next;
    logic [shift_w_lp-1:0]    shift_reg, shift_next;
    logic [lg_width_lp-1:0]   len_reg, len_next;
    logic                     tag_data_reg, tag_data_next;
    logic                     tag_en_reg, ready_reg, idle_reg;
    logic [lg_width_lp-1:0]   len_clamped;
    logic                     take_bit;
    logic                     cnt_zero;

    assign len_clamped = (len_i > lg_width_lp'(tag_max_payload_width_p))
                       ? lg_width_lp'(tag_max_payload_width_p) : len_i;
    assign cnt_zero    = (cnt_reg == '0);

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        shift_next    = shift_reg;
        len_next      = len_reg;
        tag_data_next = 1'b0;
        take_bit      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (v_i && ready_reg) begin
                    tag_data_next = 1'b1;
                    if (master_reset_i) begin
                        state_next = S_PRE;
                        cnt_next   = cnt_w_lp'(reset_len_p - 1);
                    end else begin
                        // START bit goes out now; the shift register holds everything after it
                        state_next = S_START;
                        cnt_next   = '0;
                        shift_next = {payload_i, len_clamped, data_not_reset_i, node_id_i};
                        len_next   = len_clamped;
                    end
                end
            end
            S_PRE: begin
                if (cnt_zero) begin
                    state_next = S_GAP;
                end else begin
                    cnt_next      = cnt_reg - cnt_w_lp'(1);
                    tag_data_next = 1'b1;
                end
            end
            S_START: begin
                state_next = S_NODE;
                cnt_next   = cnt_w_lp'(lg_els_lp - 1);
                take_bit   = 1'b1;
            end
            S_NODE: begin
                take_bit = 1'b1;
                if (cnt_zero) begin
                    state_next = S_DNR;
                end else begin
                    cnt_next = cnt_reg - cnt_w_lp'(1);
                end
            end
            S_DNR: begin
                state_next = S_LEN;
                cnt_next   = cnt_w_lp'(lg_width_lp - 1);
                take_bit   = 1'b1;
            end
            S_LEN: begin
                if (!cnt_zero) begin
                    cnt_next = cnt_reg - cnt_w_lp'(1);
                    take_bit = 1'b1;
                end else if (len_reg != '0) begin
                    state_next = S_PAY;
                    cnt_next   = cnt_w_lp'(len_reg) - cnt_w_lp'(1);
                    take_bit   = 1'b1;
                end else begin
                    state_next = S_GAP;
                end
            end
            S_PAY: begin
                // Payload bits beyond len stay in the shift register and are dropped
                if (cnt_zero) begin
                    state_next = S_GAP;
                end else begin
                    cnt_next = cnt_reg - cnt_w_lp'(1);
                    take_bit = 1'b1;
                end
            end
            S_GAP:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (take_bit) begin
            tag_data_next = shift_reg[0];
            shift_next    = shift_reg >> 1;
        end
    end

    always_ff @(posedge clk_i or negedge async_reset_n_i) begin
        if (!async_reset_n_i) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            shift_reg    <= '0;
            len_reg      <= '0;
            tag_data_reg <= 1'b0;
            tag_en_reg   <= 1'b0;
            ready_reg    <= 1'b0;
            idle_reg     <= 1'b1;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            shift_reg    <= shift_next;
            len_reg      <= len_next;
            tag_data_reg <= tag_data_next;
            tag_en_reg   <= (state_next != S_IDLE);
            ready_reg    <= (state_next == S_IDLE);
            idle_reg     <= (state_next == S_IDLE);
        end
    end

    assign tag_data_o  = tag_data_reg;
    assign tag_en_o    = tag_en_reg;
    assign ready_and_o = ready_reg;
    assign idle_o      = idle_reg;

endmodule
